// File: rtl/rpm_pulse_gen.sv
// RPM-to-index-pulse generator: parses five ASCII digits, divides MS_PER_MIN by the RPM and emits ChZ pulses.
// Optional macro CHZ_STRETCH_EN widens each ChZ pulse to floor(PERIOD/2) cycles.
`timescale 1ns/1ps
module rpm_pulse_gen #(
  parameter int MS_PER_MIN = 60000,
  parameter int MAX_RPM    = 30000
) (
  input  logic        clk_1ms,
  input  logic        RST,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [39:0] DIGITS_IN,
  output logic        ChZ,
  output logic        BUSY,
  output logic        ERR,
  output logic [15:0] PERIOD
);

  typedef enum logic [2:0] {IDLE, PARSE, DIVIDE, RUN, ERROR} state_t;

  localparam logic [15:0] DIVIDEND = 16'(MS_PER_MIN);
  localparam logic [16:0] RPM_CEIL = 17'(MAX_RPM);

  state_t      state_q;
  logic [39:0] digits_q;
  logic [16:0] acc_q;
  logic        bad_q;
  logic [3:0]  step_q;
  logic [15:0] rem_q;
  logic [16:0] dsr_q;
  logic [15:0] quo_q;
  logic [15:0] cnt_q;
  logic [15:0] period_q;
  logic        chz_q;
  logic        busy_q;
  logic        err_q;

  logic [7:0]  byte_cur;
  logic        byte_bad;
  logic [16:0] acc_d;
  logic [16:0] dsr_d;
  logic [16:0] rem_sh;
  logic        rem_ge;
  logic [15:0] rem_d;
  logic [15:0] quo_d;
  logic [15:0] cnt_d;
  logic        chz_d;
  logic        load_ok;

  always_comb begin
    byte_cur = digits_q[39:32];
    byte_bad = (byte_cur < 8'h30) || (byte_cur > 8'h39);
    acc_d    = acc_q * 17'd10 + {13'd0, byte_cur[3:0]};
    dsr_d    = (acc_d > RPM_CEIL) ? RPM_CEIL : acc_d;
    // One restoring step: the partial remainder always stays below the divisor.
    rem_sh   = {rem_q, quo_q[15]};
    rem_ge   = (rem_sh >= dsr_q);
    rem_d    = rem_ge ? 16'(rem_sh - dsr_q) : rem_sh[15:0];
    quo_d    = {quo_q[14:0], rem_ge};
    cnt_d    = (cnt_q >= period_q) ? 16'd1 : cnt_q + 16'd1;
`ifdef CHZ_STRETCH_EN
    chz_d    = (cnt_d <= {1'b0, period_q[15:1]});
`else
    chz_d    = (cnt_d == 16'd1);
`endif
    load_ok  = LOAD && ((state_q == IDLE) || (state_q == RUN) || (state_q == ERROR));
  end

  always_ff @(posedge clk_1ms or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      digits_q <= '0;
      acc_q    <= '0;
      bad_q    <= 1'b0;
      step_q   <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      chz_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (load_ok) begin
      state_q  <= PARSE;
      digits_q <= DIGITS_IN;
      acc_q    <= '0;
      bad_q    <= 1'b0;
      step_q   <= '0;
      cnt_q    <= '0;
      chz_q    <= 1'b0;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        PARSE: begin
          acc_q    <= acc_d;
          bad_q    <= bad_q | byte_bad;
          digits_q <= {digits_q[31:0], 8'h00};
          step_q   <= step_q + 4'd1;
          if (step_q == 4'd4) begin
            step_q <= '0;
            if (bad_q || byte_bad) begin
              state_q  <= ERROR;
              err_q    <= 1'b1;
              period_q <= '0;
              busy_q   <= 1'b0;
            end else if (acc_d == 17'd0) begin
              state_q  <= IDLE;
              period_q <= '0;
              busy_q   <= 1'b0;
            end else begin
              state_q <= DIVIDE;
              dsr_q   <= dsr_d;
              rem_q   <= '0;
              quo_q   <= DIVIDEND;
            end
          end
        end
        DIVIDE: begin
          rem_q  <= rem_d;
          quo_q  <= quo_d;
          step_q <= step_q + 4'd1;
          if (step_q == 4'd15) begin
            state_q  <= RUN;
            period_q <= quo_d;
            busy_q   <= 1'b0;
            cnt_q    <= 16'd1;
            chz_q    <= EN;
          end
        end
        RUN: begin
          // EN low freezes the phase so the pulse train resumes without slipping.
          if (EN) begin
            cnt_q <= cnt_d;
            chz_q <= chz_d;
          end else begin
            chz_q <= 1'b0;
          end
        end
        default: chz_q <= 1'b0;
      endcase
    end
  end

  assign ChZ    = chz_q;
  assign BUSY   = busy_q;
  assign ERR    = err_q;
  assign PERIOD = period_q;

endmodule

// File: tb/tb_rpm_pulse_gen.sv
// Randomised scoreboard bench for rpm_pulse_gen: requests are modelled arithmetically, a monitor checks completions and ChZ.
`timescale 1ns/1ps
module tb_rpm_pulse_gen;

  localparam int MS_PER_MIN = 60000;
  localparam int MAX_RPM    = 30000;

  logic        clk_1ms = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b1;
  logic        LOAD = 1'b0;
  logic [39:0] DIGITS_IN = '0;
  logic        ChZ;
  logic        BUSY;
  logic        ERR;
  logic [15:0] PERIOD;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected completion record: {err, period[15:0], busy_len[4:0]}
  logic [21:0] exp_q[$];

  rpm_pulse_gen #(.MS_PER_MIN(MS_PER_MIN), .MAX_RPM(MAX_RPM)) dut (
    .clk_1ms  (clk_1ms),
    .RST      (RST),
    .EN       (EN),
    .LOAD     (LOAD),
    .DIGITS_IN(DIGITS_IN),
    .ChZ      (ChZ),
    .BUSY     (BUSY),
    .ERR      (ERR),
    .PERIOD   (PERIOD)
  );

  always #5 clk_1ms = ~clk_1ms;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] ref_result(input logic [39:0] d);
    int        val;
    bit        bad;
    logic [7:0] b;
    val = 0;
    bad = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      b = d[i*8 +: 8];
      if (b < 8'h30 || b > 8'h39) bad = 1'b1;
      else val = val * 10 + int'(b) - 48;
    end
    if (bad) return {1'b1, 16'd0, 5'd5};
    if (val == 0) return {1'b0, 16'd0, 5'd5};
    if (val > MAX_RPM) val = MAX_RPM;
    return {1'b0, 16'(MS_PER_MIN / val), 5'd21};
  endfunction

  // Monitor: inputs captured at the edge, outputs sampled 1ns later.
  bit          prev_busy  = 1'b0;
  bit          run_active = 1'b0;
  bit          exp_chz    = 1'b0;
  bit          cur_err    = 1'b0;
  int          busy_len   = 0;
  int          pos        = 0;
  int          cur_period = 0;
  logic [21:0] e;

  always @(posedge clk_1ms) begin : mon
    bit en_e;
    bit rst_e;
    en_e  = EN;
    rst_e = RST;
    #1;
    if (rst_e) begin
      exp_q.delete();
      prev_busy  = 1'b0;
      run_active = 1'b0;
      exp_chz    = 1'b0;
      cur_err    = 1'b0;
      cur_period = 0;
      busy_len   = 0;
      check("rst_busy", BUSY, 0);
      check("rst_err", ERR, 0);
      check("rst_period", PERIOD, 0);
      check("rst_chz", ChZ, 0);
    end else begin
      if (BUSY === 1'b1) begin
        busy_len   = prev_busy ? busy_len + 1 : 1;
        run_active = 1'b0;
        exp_chz    = 1'b0;
        check("busy_err", ERR, 0);
        check("busy_hold_period", PERIOD, cur_period);
      end else begin
        if (prev_busy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got completion expected none at %0t", $time);
            run_active = 1'b0;
            exp_chz    = 1'b0;
          end else begin
            e = exp_q.pop_front();
            check("busy_len", busy_len, 32'(e[4:0]));
            cur_err    = e[21];
            cur_period = int'(e[20:5]);
            run_active = (cur_period != 0);
            pos        = 0;
            exp_chz    = run_active && en_e;
          end
        end else if (run_active) begin
          if (en_e) begin
            pos = (pos + 1) % cur_period;
`ifdef CHZ_STRETCH_EN
            exp_chz = (pos < cur_period / 2);
`else
            exp_chz = (pos == 0);
`endif
          end else begin
            exp_chz = 1'b0;
          end
        end
        check("period", PERIOD, cur_period);
        check("err", ERR, cur_err);
      end
      check("chz", ChZ, exp_chz);
      prev_busy = (BUSY === 1'b1);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk_1ms);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (BUSY === 1'b1 && k < 100) begin
      @(negedge clk_1ms);
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle_timeout: got BUSY=%0b expected 0 within 100 cycles", BUSY);
    end
  endtask

  task automatic do_load(input logic [39:0] d);
    wait_idle();
    exp_q.push_back(ref_result(d));
    LOAD      = 1'b1;
    DIGITS_IN = d;
    @(negedge clk_1ms);
    LOAD      = 1'b0;
  endtask

  task automatic do_ignored_load(input logic [39:0] d);
    check("busy_before_ignored", BUSY, 1);
    LOAD      = 1'b1;
    DIGITS_IN = d;
    @(negedge clk_1ms);
    LOAD      = 1'b0;
  endtask

  function automatic logic [39:0] rand_digits();
    logic [39:0] r;
    logic [7:0]  junk[5];
    junk[0] = 8'h2F; junk[1] = 8'h3A; junk[2] = 8'h41; junk[3] = 8'h20; junk[4] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(0, 24) == 0) r[i*8 +: 8] = junk[$urandom_range(0, 4)];
      else r[i*8 +: 8] = 8'h30 + 8'($urandom_range(0, 9));
    end
    if ($urandom_range(0, 2) == 0) r[39:16] = "000";
    return r;
  endfunction

  initial begin : drv
    repeat (3) @(negedge clk_1ms);
    RST = 1'b0;
    run(2);

    do_load("01000");
    run(140);
    do_load("00000");
    run(10);

    do_load("99999");
    run(12);
    do_load("00007");
    run(20);

    do_load("0A123");
    run(6);
    do_load("06000");
    wait_idle();
    run(30);

    do_load("00500");
    wait_idle();
    run(150);
    do_load("06000");
    run(3);
    do_ignored_load("00001");
    run(10);
    do_ignored_load("99999");
    wait_idle();
    run(40);

    for (int i = 0; i < 6; i++) begin
      EN = 1'b0;
      run($urandom_range(1, 7));
      EN = 1'b1;
      run($urandom_range(3, 15));
    end

    EN = 1'b0;
    do_load("00100");
    wait_idle();
    run(5);
    EN = 1'b1;
    run(30);

    for (int i = 0; i < 15; i++) begin
      do_load(rand_digits());
      if ($urandom_range(0, 1) == 1) begin
        run(2);
        do_ignored_load(rand_digits());
      end
      wait_idle();
      run($urandom_range(0, 40));
    end

    do_load("01000");
    run(12);
    RST = 1'b1;
    #1;
    check("async_rst_busy", BUSY, 0);
    check("async_rst_err", ERR, 0);
    check("async_rst_period", PERIOD, 0);
    check("async_rst_chz", ChZ, 0);
    @(negedge clk_1ms);
    RST = 1'b0;
    run(3);

    do_load("01000");
    wait_idle();
    run(70);

    wait_idle();
    run(3);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rpm_pulse_gen.md
RPM_PULSE_GEN -- requirements
Module: rpm_pulse_gen

Interface
REQ-001 SHALL have parameter MS_PER_MIN, default 60000: clk_1ms cycles per minute (dividend).
REQ-002 SHALL have parameter MAX_RPM, default 30000: clamp ceiling for requested RPM (gives minimum period 2).
REQ-003 SHALL have port clk_1ms  input  1  1 ms system clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port EN  input  1  output enable; low forces ChZ low and holds the period counter.
REQ-006 SHALL have port LOAD  input  1  one-cycle strobe; samples DIGITS_IN.
REQ-007 SHALL have port DIGITS_IN  input  40  five ASCII digits, [39:32] most significant, [7:0] least.
REQ-008 SHALL have port ChZ  output  1  emulated index pulse train.
REQ-009 SHALL have port BUSY  output  1  high while parsing or dividing.
REQ-010 SHALL have port ERR  output  1  high after a LOAD containing a non-digit byte.
REQ-011 SHALL have port PERIOD  output  16  active period in clk_1ms cycles; 0 = stopped.

Function
REQ-012 SHALL implement states IDLE, PARSE, DIVIDE, RUN, ERROR.
REQ-013 LOAD SHALL be accepted only in IDLE, RUN or ERROR; LOAD in PARSE or DIVIDE SHALL be ignored.
REQ-014 On accepted LOAD SHALL latch DIGITS_IN and enter PARSE; BUSY high from the next cycle.
REQ-015 PARSE SHALL take exactly 5 cycles, one byte per cycle, MSD first: acc = acc*10 + (byte - 8'h30), 17-bit acc.
REQ-016 Any byte outside 8'h30..8'h39 SHALL end PARSE at the end of cycle 5, enter ERROR: ERR=1, ChZ=0, PERIOD=0.
REQ-017 acc = 0 SHALL go to IDLE with PERIOD=0, ChZ=0, BUSY=0, skipping DIVIDE.
REQ-018 acc > MAX_RPM SHALL be clamped to MAX_RPM before DIVIDE.
REQ-019 DIVIDE SHALL be a restoring divider taking exactly 16 cycles: PERIOD = floor(MS_PER_MIN / acc), remainder discarded.
REQ-020 BUSY SHALL be high exactly 21 cycles (5 PARSE + 16 DIVIDE) for a nonzero valid request.
REQ-021 ChZ SHALL be low throughout PARSE and DIVIDE; PERIOD SHALL keep its old value until DIVIDE completes.
REQ-022 On entering RUN, period counter SHALL load 1; ChZ high on the first RUN cycle, then every PERIOD cycles.
REQ-023 ChZ pulse width SHALL be exactly one clk_1ms cycle (unless REQ-029).
REQ-024 Counter SHALL wrap from PERIOD to 1, asserting ChZ on the wrap cycle; no drift over any number of periods.
REQ-025 EN low in RUN SHALL hold the counter and force ChZ=0; EN rising SHALL resume from the held count.
REQ-026 LOAD with EN low SHALL still parse/divide; EN affects only ChZ and the counter.
REQ-027 A valid LOAD from ERROR SHALL clear ERR when PARSE starts.

Reset
REQ-028 RST high SHALL immediately force IDLE, ChZ=0, BUSY=0, ERR=0, PERIOD=0, accumulator, divider and counter cleared, including mid-PARSE or mid-DIVIDE.

Configuration
REQ-029 Macro CHZ_STRETCH_EN defined: ChZ high for floor(PERIOD/2) cycles from each pulse start (PERIOD=2 gives 1 cycle); undefined: one-cycle pulse per REQ-023.

Verification
REQ-030 LOAD "01000", EN=1 -> BUSY 21 cycles, PERIOD=60, ChZ one-cycle pulses 60 cycles apart, first pulse on cycle 22 after LOAD.
REQ-031 LOAD "00000" while running at PERIOD=60 -> PERIOD=0, ChZ stays low, BUSY=0 after 5 cycles.
REQ-032 LOAD "99999" -> clamped to 30000, PERIOD=2, ChZ alternates 1,0; LOAD "00007" -> PERIOD=8571.
REQ-033 LOAD "0A123" -> ERR=1 after 5 cycles, ChZ=0, PERIOD=0; then LOAD "06000" -> ERR=0, PERIOD=10.
REQ-034 Running "00500" (PERIOD=120), LOAD "06000" -> ChZ low 21 cycles, then PERIOD=10 pulses; second LOAD during BUSY ignored.
REQ-035 RST pulsed on DIVIDE cycle 8 -> all outputs 0 same cycle, IDLE; with CHZ_STRETCH_EN, "01000" -> ChZ high 30 of every 60 cycles.
